// File: rtl/active_list_if.sv
// -----------------------------------------------------------------------------
// active_list_if
// Bundle of the dispatch, writeback and retirement signals for the active list
// (reorder buffer).
//   slave  : the active list itself
//   master : the core side (dispatch, writeback, retirement logic)
// Signal groups:
//   alloc_*  : dispatch allocates one entry per cycle, receives alloc_index
//   cmpl_*   : writeback marks an entry done (optionally mispredicted)
//   commit_* : head entry presented for in-order retirement
//   flush    : squash pulse when a mispredicted branch commits
//   count    : number of occupied entries (0..DEPTH)
// -----------------------------------------------------------------------------
interface active_list_if #(
    parameter int IDX_W  = 5,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6
);
    // dispatch
    logic              alloc_valid;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_index;
    logic              alloc_uses_rw;
    logic [AREG_W-1:0] alloc_areg;
    logic [PREG_W-1:0] alloc_preg;
    logic [PREG_W-1:0] alloc_old_preg;
    // writeback
    logic              cmpl_valid;
    logic [IDX_W-1:0]  cmpl_index;
    logic              cmpl_mispredict;
    // retirement
    logic              commit_valid;
    logic              commit_ready;
    logic [IDX_W-1:0]  commit_index;
    logic              commit_uses_rw;
    logic [AREG_W-1:0] commit_areg;
    logic [PREG_W-1:0] commit_preg;
    logic [PREG_W-1:0] commit_old_preg;
    // status
    logic              flush;
    logic [IDX_W:0]    count;

    modport slave (
        input  alloc_valid, alloc_uses_rw, alloc_areg, alloc_preg, alloc_old_preg,
        output alloc_ready, alloc_index,
        input  cmpl_valid, cmpl_index, cmpl_mispredict,
        output commit_valid, commit_index, commit_uses_rw, commit_areg,
        output commit_preg, commit_old_preg,
        input  commit_ready,
        output flush, count
    );

    modport master (
        output alloc_valid, alloc_uses_rw, alloc_areg, alloc_preg, alloc_old_preg,
        input  alloc_ready, alloc_index,
        output cmpl_valid, cmpl_index, cmpl_mispredict,
        input  commit_valid, commit_index, commit_uses_rw, commit_areg,
        input  commit_preg, commit_old_preg,
        output commit_ready,
        input  flush, count
    );
endinterface

// File: rtl/active_list.sv
// -----------------------------------------------------------------------------
// active_list
// 32-entry in-order retirement buffer (reorder buffer) for the out-of-order
// MIPS core. Dispatch allocates at the tail and receives the entry index,
// writeback marks entries done by index, and the head entry commits in program
// order, handing back the previous physical mapping for the free list. A
// mispredicted branch commits normally and then squashes every younger entry.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset, discards all entries
//   bus   : active_list_if.slave (alloc_*, cmpl_*, commit_*, flush, count)
// -----------------------------------------------------------------------------
module active_list #(
    parameter int DEPTH  = 32,
    parameter int IDX_W  = 5,
    parameter int AREG_W = 5,
    parameter int PREG_W = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    active_list_if.slave  bus
);

    localparam int CNT_W = IDX_W + 1;

    // per-entry status bits
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] done_reg,  done_next;
    logic [DEPTH-1:0] misp_reg,  misp_next;

    // pointers and occupancy
    logic [IDX_W-1:0] head_reg,  head_next;
    logic [IDX_W-1:0] tail_reg,  tail_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // payload captured at dispatch; only meaningful while the entry is valid,
    // so it carries no reset
    logic              uses_rw_mem  [DEPTH];
    logic [AREG_W-1:0] areg_mem     [DEPTH];
    logic [PREG_W-1:0] preg_mem     [DEPTH];
    logic [PREG_W-1:0] old_preg_mem [DEPTH];

    logic commit_ok;
    logic commit_fire;
    logic flush_now;
    logic alloc_ok;
    logic alloc_fire;
    logic cmpl_accept;

    // -------------------------------------------------------------------------
    // Handshake decode. Everything here depends only on registered state plus
    // commit_ready (and the incoming valids for the fire terms, which never
    // feed an output). Completion has no bypass into commit_ok: a head that
    // completes at edge N is seen done only from cycle N+1 on.
    // -------------------------------------------------------------------------
    assign commit_ok   = valid_reg[head_reg] & done_reg[head_reg];
    assign commit_fire = commit_ok & bus.commit_ready;
    assign flush_now   = commit_fire & misp_reg[head_reg];

    // No bypass when full: a commit in the same cycle frees a slot only for
    // the following cycle.
    assign alloc_ok    = (count_reg != CNT_W'(DEPTH)) & ~flush_now;
    assign alloc_fire  = bus.alloc_valid & alloc_ok;

    // Completions to invalid entries are dropped, as are all completions in
    // the flush cycle (their targets are about to be squashed anyway).
    assign cmpl_accept = bus.cmpl_valid & valid_reg[bus.cmpl_index] & ~flush_now;

    // -------------------------------------------------------------------------
    // Per-entry next-state. The entry at the tail can never be the committing
    // head or a completion target in the same cycle (it is invalid whenever an
    // allocation is possible), so allocation simply takes priority.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic alloc_hit;
            logic commit_hit;
            logic cmpl_hit;
            logic e_valid_next;
            logic e_done_next;
            logic e_misp_next;

            assign alloc_hit  = alloc_fire  & (tail_reg       == IDX_W'(gi));
            assign commit_hit = commit_fire & (head_reg       == IDX_W'(gi));
            assign cmpl_hit   = cmpl_accept & (bus.cmpl_index == IDX_W'(gi));

            always_comb begin
                e_valid_next = valid_reg[gi];
                e_done_next  = done_reg[gi];
                e_misp_next  = misp_reg[gi];
                if (flush_now) begin
                    e_valid_next = 1'b0;
                    e_done_next  = 1'b0;
                    e_misp_next  = 1'b0;
                end else if (alloc_hit) begin
                    e_valid_next = 1'b1;
                    e_done_next  = 1'b0;
                    e_misp_next  = 1'b0;
                end else begin
                    if (commit_hit) begin
                        e_valid_next = 1'b0;
                    end
                    // a repeated completion re-marks done and overwrites the
                    // mispredict flag with the latest report
                    if (cmpl_hit) begin
                        e_done_next = 1'b1;
                        e_misp_next = bus.cmpl_mispredict;
                    end
                end
            end

            assign valid_next[gi] = e_valid_next;
            assign done_next[gi]  = e_done_next;
            assign misp_next[gi]  = e_misp_next;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pointer / count next-state. On flush the branch itself retires, so both
    // pointers restart just past it with an empty list.
    // -------------------------------------------------------------------------
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (flush_now) begin
            head_next  = head_reg + IDX_W'(1);
            tail_next  = head_reg + IDX_W'(1);
            count_next = '0;
        end else begin
            head_next  = head_reg + IDX_W'(commit_fire);
            tail_next  = tail_reg + IDX_W'(alloc_fire);
            count_next = count_reg + CNT_W'(alloc_fire) - CNT_W'(commit_fire);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            done_reg  <= '0;
            misp_reg  <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            done_reg  <= done_next;
            misp_reg  <= misp_next;
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            uses_rw_mem[tail_reg]  <= bus.alloc_uses_rw;
            areg_mem[tail_reg]     <= bus.alloc_areg;
            preg_mem[tail_reg]     <= bus.alloc_preg;
            old_preg_mem[tail_reg] <= bus.alloc_old_preg;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. The head payload is read asynchronously so that commit_* are
    // valid in the same cycle as commit_valid.
    // -------------------------------------------------------------------------
    assign bus.alloc_ready     = alloc_ok;
    assign bus.alloc_index     = tail_reg;
    assign bus.commit_valid    = commit_ok;
    assign bus.commit_index    = head_reg;
    assign bus.commit_uses_rw  = uses_rw_mem[head_reg];
    assign bus.commit_areg     = areg_mem[head_reg];
    assign bus.commit_preg     = preg_mem[head_reg];
    assign bus.commit_old_preg = old_preg_mem[head_reg];
    assign bus.flush           = flush_now;
    assign bus.count           = count_reg;

endmodule

// File: tb/tb_active_list.sv
// -----------------------------------------------------------------------------
// tb_active_list
// Self-checking bench for active_list. A negedge monitor keeps a reference
// model (expected entry queue, done/mispredict flags, tail, count), pushes an
// expected entry on every allocation and pops/compares it on every commit.
// Directed sequences in the main process add targeted timing checks.
// -----------------------------------------------------------------------------
module tb_active_list;

    localparam int DEPTH  = 32;
    localparam int IDX_W  = 5;
    localparam int AREG_W = 5;
    localparam int PREG_W = 6;

    logic clk;
    logic rst_n;

    active_list_if #(.IDX_W(IDX_W), .AREG_W(AREG_W), .PREG_W(PREG_W)) al_bus ();

    active_list #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .AREG_W(AREG_W),
        .PREG_W(PREG_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (al_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              uses_rw;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] old_preg;
    } ent_t;

    ent_t exp_q[$];
    logic m_done [DEPTH];
    logic m_misp [DEPTH];
    int   m_tail;
    int   m_count;

    ent_t mon_e;
    ent_t mon_new;
    logic mon_cv, mon_cfire, mon_afire, mon_flush, mon_cmpl_ok;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_tail  = 0;
            m_count = 0;
            for (int i = 0; i < DEPTH; i++) begin
                m_done[i] = 1'b0;
                m_misp[i] = 1'b0;
            end
        end else begin
            mon_cv    = (exp_q.size() > 0) && m_done[exp_q[0].idx];
            mon_cfire = mon_cv && al_bus.commit_ready;
            mon_flush = mon_cfire && m_misp[exp_q[0].idx];
            mon_afire = al_bus.alloc_valid && (m_count < DEPTH) && !mon_flush;

            check("commit_valid", 32'(al_bus.commit_valid), 32'(mon_cv));
            check("count",        32'(al_bus.count), m_count);
            check("flush",        32'(al_bus.flush), 32'(mon_flush));
            check("alloc_ready",  32'(al_bus.alloc_ready), 32'((m_count < DEPTH) && !mon_flush));
            check("alloc_index",  32'(al_bus.alloc_index), m_tail);

            mon_cmpl_ok = 1'b0;
            if (al_bus.cmpl_valid && !mon_flush) begin
                foreach (exp_q[i]) begin
                    if (exp_q[i].idx == al_bus.cmpl_index) mon_cmpl_ok = 1'b1;
                end
            end

            mon_e = '0;
            if (mon_cfire) begin
                mon_e = exp_q.pop_front();
                check("commit_index",    32'(al_bus.commit_index),    32'(mon_e.idx));
                check("commit_uses_rw",  32'(al_bus.commit_uses_rw),  32'(mon_e.uses_rw));
                check("commit_areg",     32'(al_bus.commit_areg),     32'(mon_e.areg));
                check("commit_preg",     32'(al_bus.commit_preg),     32'(mon_e.preg));
                check("commit_old_preg", 32'(al_bus.commit_old_preg), 32'(mon_e.old_preg));
                $display("[TB] commit idx=%0d areg=%0d preg=%0d old_preg=%0d flush=%0d",
                         al_bus.commit_index, al_bus.commit_areg, al_bus.commit_preg,
                         al_bus.commit_old_preg, al_bus.flush);
            end

            if (mon_cmpl_ok) begin
                m_done[al_bus.cmpl_index] = 1'b1;
                m_misp[al_bus.cmpl_index] = al_bus.cmpl_mispredict;
            end

            if (mon_flush) begin
                exp_q.delete();
                m_tail  = (int'(mon_e.idx) + 1) % DEPTH;
                m_count = 0;
                for (int i = 0; i < DEPTH; i++) begin
                    m_done[i] = 1'b0;
                    m_misp[i] = 1'b0;
                end
            end else begin
                if (mon_afire) begin
                    mon_new.idx      = IDX_W'(m_tail);
                    mon_new.uses_rw  = al_bus.alloc_uses_rw;
                    mon_new.areg     = al_bus.alloc_areg;
                    mon_new.preg     = al_bus.alloc_preg;
                    mon_new.old_preg = al_bus.alloc_old_preg;
                    exp_q.push_back(mon_new);
                    m_done[m_tail] = 1'b0;
                    m_misp[m_tail] = 1'b0;
                    $display("[TB] alloc  idx=%0d areg=%0d preg=%0d old_preg=%0d",
                             m_tail, al_bus.alloc_areg, al_bus.alloc_preg, al_bus.alloc_old_preg);
                    m_tail = (m_tail + 1) % DEPTH;
                end
                m_count = m_count + int'(mon_afire) - int'(mon_cfire);
            end
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        al_bus.alloc_valid     = 1'b0;
        al_bus.alloc_uses_rw   = 1'b0;
        al_bus.alloc_areg      = '0;
        al_bus.alloc_preg      = '0;
        al_bus.alloc_old_preg  = '0;
        al_bus.cmpl_valid      = 1'b0;
        al_bus.cmpl_index      = '0;
        al_bus.cmpl_mispredict = 1'b0;
        al_bus.commit_ready    = 1'b1;
    endtask

    task automatic set_alloc(input int a, input int p, input int op);
        al_bus.alloc_valid    = 1'b1;
        al_bus.alloc_uses_rw  = 1'b1;
        al_bus.alloc_areg     = AREG_W'(a);
        al_bus.alloc_preg     = PREG_W'(p);
        al_bus.alloc_old_preg = PREG_W'(op);
    endtask

    task automatic set_cmpl(input int idx, input logic misp);
        al_bus.cmpl_valid      = 1'b1;
        al_bus.cmpl_index      = IDX_W'(idx);
        al_bus.cmpl_mispredict = misp;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        at_neg();
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            set_alloc(i % 32, (i + 7) % 64, (i + 40) % 64);
            tick();
        end
        al_bus.alloc_valid = 1'b0;
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        rst_n = 1'b0;
        idle_inputs();
        #1;
        check("rst_alloc_ready",  32'(al_bus.alloc_ready), 1);
        check("rst_commit_valid", 32'(al_bus.commit_valid), 0);
        do_reset();
        check("rst_alloc_index",  32'(al_bus.alloc_index), 0);
        check("rst_count",        32'(al_bus.count), 0);
        check("rst_flush",        32'(al_bus.flush), 0);

        // basic alloc of three entries
        for (int i = 0; i < 3; i++) begin
            set_alloc(i + 1, 33 + i, i + 1);
            at_neg();
            check("t1_alloc_index", 32'(al_bus.alloc_index), i);
            tick();
        end
        al_bus.alloc_valid = 1'b0;
        at_neg();
        check("t1_count", 32'(al_bus.count), 3);
        check("t1_commit_valid", 32'(al_bus.commit_valid), 0);

        // out-of-order completion 2,0,1; commit follows index 0 by one cycle
        set_cmpl(2, 1'b0);
        tick();
        set_cmpl(0, 1'b0);
        at_neg();
        check("t2_no_early_commit", 32'(al_bus.commit_valid), 0);
        tick();
        set_cmpl(1, 1'b0);
        at_neg();
        check("t2_commit_rise", 32'(al_bus.commit_valid), 1);
        check("t2_commit_old0", 32'(al_bus.commit_old_preg), 1);
        tick();
        al_bus.cmpl_valid = 1'b0;
        for (int w = 0; w < 10 && al_bus.count != 0; w++) tick();
        at_neg();
        check("t2_drained", 32'(al_bus.count), 0);

        // full boundary: no alloc bypass on the commit cycle
        do_reset();
        al_bus.commit_ready = 1'b1;
        fill(32);
        at_neg();
        check("t3_full_count", 32'(al_bus.count), 32);
        check("t3_full_ready", 32'(al_bus.alloc_ready), 0);
        tick();
        set_cmpl(0, 1'b0);
        tick();
        al_bus.cmpl_valid = 1'b0;
        set_alloc(9, 9, 9);
        at_neg();
        check("t3_commit_at_full", 32'(al_bus.commit_valid), 1);
        check("t3_ready_still_0",  32'(al_bus.alloc_ready), 0);
        tick();
        at_neg();
        check("t3_ready_back",     32'(al_bus.alloc_ready), 1);
        check("t3_reuse_index0",   32'(al_bus.alloc_index), 0);
        tick();
        al_bus.alloc_valid = 1'b0;
        at_neg();
        check("t3_refull", 32'(al_bus.count), 32);

        // 40 alloc/commit pairs across the wrap point
        do_reset();
        for (int k = 0; k < 40; k++) begin
            set_alloc(k % 32, k % 64, (k + 1) % 64);
            al_bus.cmpl_valid = 1'b0;
            at_neg();
            check("t4_index", 32'(al_bus.alloc_index), k % 32);
            check("t4_count_le1", 32'(al_bus.count <= 1), 1);
            tick();
            al_bus.alloc_valid = 1'b0;
            set_cmpl(k % 32, 1'b0);
            tick();
        end
        al_bus.cmpl_valid = 1'b0;
        tick();
        at_neg();
        check("t4_final_count", 32'(al_bus.count), 0);
        check("t4_tail_wrapped", 32'(al_bus.alloc_index), 40 % 32);

        // mispredicted branch at the head squashes younger entries
        do_reset();
        al_bus.commit_ready = 1'b0;
        fill(5);
        set_cmpl(0, 1'b1);
        tick();
        for (int i = 1; i < 5; i++) begin
            set_cmpl(i, 1'b0);
            tick();
        end
        al_bus.cmpl_valid   = 1'b0;
        al_bus.commit_ready = 1'b1;
        set_alloc(3, 3, 3);
        at_neg();
        check("t5_flush",        32'(al_bus.flush), 1);
        check("t5_flush_commit", 32'(al_bus.commit_index), 0);
        check("t5_flush_ready",  32'(al_bus.alloc_ready), 0);
        tick();
        al_bus.alloc_valid = 1'b0;
        at_neg();
        check("t5_after_count", 32'(al_bus.count), 0);
        check("t5_after_tail",  32'(al_bus.alloc_index), 1);
        check("t5_after_head",  32'(al_bus.commit_index), 1);
        check("t5_after_cv",    32'(al_bus.commit_valid), 0);
        repeat (4) tick();

        // flush taken while full
        do_reset();
        al_bus.commit_ready = 1'b0;
        fill(32);
        set_cmpl(0, 1'b1);
        tick();
        al_bus.cmpl_valid   = 1'b0;
        al_bus.commit_ready = 1'b1;
        at_neg();
        check("t5b_flush_full", 32'(al_bus.flush), 1);
        tick();
        at_neg();
        check("t5b_empty",  32'(al_bus.count), 0);
        check("t5b_ready",  32'(al_bus.alloc_ready), 1);

        // asynchronous reset with a committable head
        do_reset();
        al_bus.commit_ready = 1'b0;
        fill(10);
        set_cmpl(0, 1'b0);
        tick();
        al_bus.cmpl_valid = 1'b0;
        at_neg();
        check("t6_pre_count", 32'(al_bus.count), 10);
        check("t6_pre_cv",    32'(al_bus.commit_valid), 1);
        #2;
        rst_n = 1'b0;
        al_bus.commit_ready = 1'b1;
        #1;
        check("t6_rst_cv",    32'(al_bus.commit_valid), 0);
        check("t6_rst_count", 32'(al_bus.count), 0);
        check("t6_rst_ready", 32'(al_bus.alloc_ready), 1);
        check("t6_rst_index", 32'(al_bus.alloc_index), 0);
        check("t6_rst_flush", 32'(al_bus.flush), 0);
        tick();
        at_neg();
        #2 rst_n = 1'b1;
        repeat (3) tick();
        at_neg();
        check("t6_post_cv", 32'(al_bus.commit_valid), 0);
        check("t6_post_head", 32'(al_bus.commit_index), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
